// File: rtl/register_file.sv
// Purpose: 32-entry architectural integer register file (x0 hardwired to zero)
//          with one writeback write port, two decode read ports and a write counter.
// Latency: reads are combinational (zero cycles); writes commit on the rising edge.
// Backpressure: none; a write is always accepted in the cycle it is presented.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset (clears every register and WriteCount)
//   RegWriteEn  write enable from writeback
//   RegWrAddr   destination register index
//   RegWrData   write data
//   Rs1D/Rs2D   decode-stage read indices
//   RD1D/RD2D   read data (optionally forwarded from the same-cycle write)
//   WriteCount  number of committed writes to non-zero registers, wraps silently
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BYPASS_EN  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  RegWriteEn,
   input  logic [ADDR_WIDTH-1:0] RegWrAddr,
   input  logic [DATA_WIDTH-1:0] RegWrData,
   input  logic [ADDR_WIDTH-1:0] Rs1D,
   input  logic [ADDR_WIDTH-1:0] Rs2D,
   output logic [DATA_WIDTH-1:0] RD1D,
   output logic [DATA_WIDTH-1:0] RD2D,
   output logic [31:0]           WriteCount
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regMem [DEPTH];
   logic [31:0]           writeCnt;
   logic                  writeHit;

   // A write to x0 is dropped entirely: it neither updates storage, nor counts,
   // nor forwards. Entry 0 is still cleared on reset and never written, so it
   // stays zero, but reads of x0 are forced to zero regardless.
   assign writeHit = RegWriteEn && (RegWrAddr != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regMem[i] <= '0;
         end
         writeCnt <= '0;
      end else if (writeHit) begin
         regMem[RegWrAddr] <= RegWrData;
         writeCnt          <= writeCnt + 32'd1;
      end
   end

   // Read mux: x0 first, then write-first forwarding, then the stored value.
   // All inputs are passed as arguments so the continuous assigns are
   // sensitive to every signal the result depends on.
   function automatic logic [DATA_WIDTH-1:0] readPort(
      input logic [ADDR_WIDTH-1:0] rdAddr,
      input logic                  wrHit,
      input logic [ADDR_WIDTH-1:0] wrAddr,
      input logic [DATA_WIDTH-1:0] wrData,
      input logic [DATA_WIDTH-1:0] stored
   );
      logic [DATA_WIDTH-1:0] result;
      result = stored;
      if (rdAddr == '0) begin
         result = '0;
      end else if ((BYPASS_EN != 0) && wrHit && (rdAddr == wrAddr)) begin
         result = wrData;
      end
      return result;
   endfunction

   assign RD1D = readPort(Rs1D, writeHit, RegWrAddr, RegWrData, regMem[Rs1D]);
   assign RD2D = readPort(Rs2D, writeHit, RegWrAddr, RegWrData, regMem[Rs2D]);

   assign WriteCount = writeCnt;

endmodule
